mda_vram_arbiter: RTL and testbench

// - Consumes the MDA sequencer strobes and owns the single-port 8-bit VRAM.
// - Performs display fetches on vram_read (char then attribute) for the attribute/pixel pipeline.
// - Fits 3-cycle ISA CPU reads/writes into the isa_op_enable window (sequencer states 6..15 of 18).
// - Sits between the sequencer/CRTC, the ISA bus interface and the external SRAM pins.

---
 rtl/mda_vram_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mda_vram_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mda_vram_arbiter.sv
// VRAM owner: display fetches take the bus whenever vram_read is high; ISA ops run in the sequencer window.
// Optional MDA_POSTED_WRITE_EN: writes ack one cycle after acceptance and complete later from a 1-entry buffer.
module mda_vram_arbiter #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vram_read,
    input  logic                  vram_read_a0,
    input  logic                  vram_read_char,
    input  logic                  vram_read_att,
    input  logic                  isa_op_enable,
    input  logic [ADDR_WIDTH-2:0] crtc_addr,
    input  logic                  isa_req,
    input  logic                  isa_we,
    input  logic [ADDR_WIDTH-1:0] isa_addr,
    input  logic [7:0]            isa_din,
    output logic                  isa_ack,
    output logic [7:0]            isa_dout,
    output logic [7:0]            vram_char,
    output logic [7:0]            vram_att,
    output logic [ADDR_WIDTH-1:0] ram_a,
    input  logic [7:0]            ram_d_in,
    output logic [7:0]            ram_d_out,
    output logic                  ram_we_l,
    output logic                  ram_oe_l,
    output logic                  collision_err
);

`ifdef MDA_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, PEND, ADDR, STROBE, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              din_q, din_d;
    logic                    posted_q, posted_d;
    logic                    posted_ack_q, posted_ack_d;
    logic [7:0]              isa_dout_q, isa_dout_d;
    logic [7:0]              vram_char_q, vram_char_d;
    logic [7:0]              vram_att_q, vram_att_d;
    logic [ADDR_WIDTH-1:0]   ram_a_q, ram_a_d;
    logic                    collision_q, collision_d;
    logic                    done_ack;
    logic                    oe_l, we_l;

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_d       = addr_q;
        din_d        = din_q;
        posted_d     = posted_q;
        posted_ack_d = 1'b0;
        isa_dout_d   = isa_dout_q;
        vram_char_d  = vram_char_q;
        vram_att_d   = vram_att_q;
        collision_d  = collision_q;
        ram_a_d      = ram_a_q;
        done_ack     = 1'b0;
        oe_l         = 1'b1;
        we_l         = 1'b1;

        case (state_q)
            IDLE: begin
                if (isa_req) begin
                    we_d         = isa_we;
                    addr_d       = isa_addr;
                    din_d        = isa_din;
                    posted_d     = POSTED && isa_we;
                    posted_ack_d = POSTED && isa_we;
                    state_d      = PEND;
                end
            end
            PEND: begin
                if (isa_op_enable && !vram_read) state_d = ADDR;
            end
            ADDR: begin
                ram_a_d = addr_q;
                oe_l    = we_q;
                if (vram_read) begin
                    collision_d = 1'b1;
                    state_d     = PEND;
                end else begin
                    state_d     = STROBE;
                end
            end
            STROBE: begin
                ram_a_d = addr_q;
                if (we_q) we_l = 1'b0;
                else      oe_l = 1'b0;
                if (vram_read) begin
                    collision_d = 1'b1;
                    state_d     = PEND;
                end else begin
                    if (!we_q) isa_dout_d = ram_d_in;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_ack = !posted_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Display always wins the bus; a write strobe in flight is suppressed.
        if (vram_read) begin
            ram_a_d = {crtc_addr, vram_read_a0};
            oe_l    = 1'b0;
            we_l    = 1'b1;
        end

        if (vram_read_char) vram_char_d = ram_d_in;
        if (vram_read_att)  vram_att_d  = ram_d_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            din_q        <= 8'h00;
            posted_q     <= 1'b0;
            posted_ack_q <= 1'b0;
            isa_dout_q   <= 8'h00;
            vram_char_q  <= 8'h00;
            vram_att_q   <= 8'h00;
            ram_a_q      <= '0;
            collision_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            posted_q     <= posted_d;
            posted_ack_q <= posted_ack_d;
            isa_dout_q   <= isa_dout_d;
            vram_char_q  <= vram_char_d;
            vram_att_q   <= vram_att_d;
            ram_a_q      <= ram_a_d;
            collision_q  <= collision_d;
        end
    end

    // ram_a is driven combinationally so the address is valid in the same cycle as oe/we.
    assign ram_a         = ram_a_d;
    assign ram_oe_l      = oe_l;
    assign ram_we_l      = we_l;
    assign ram_d_out     = din_q;
    assign isa_ack       = done_ack | posted_ack_q;
    assign isa_dout      = isa_dout_q;
    assign vram_char     = vram_char_q;
    assign vram_att      = vram_att_q;
    assign collision_err = collision_q;

endmodule

// File: tb/tb_mda_vram_arbiter.sv
// Bench for mda_vram_arbiter: sequencer and SRAM models, ISA stimulus, ack scoreboard.
module tb_mda_vram_arbiter;

`ifdef MDA_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        vram_read, vram_read_a0, vram_read_char, vram_read_att, isa_op_enable;
    logic [10:0] crtc_addr;
    logic        isa_req, isa_we;
    logic [11:0] isa_addr;
    logic [7:0]  isa_din, isa_dout, vram_char, vram_att;
    logic        isa_ack;
    logic [11:0] ram_a;
    logic [7:0]  ram_d_in, ram_d_out;
    logic        ram_we_l, ram_oe_l, collision_err;

    mda_vram_arbiter #(.ADDR_WIDTH(12)) dut (
        .clk(clk), .reset(reset),
        .vram_read(vram_read), .vram_read_a0(vram_read_a0),
        .vram_read_char(vram_read_char), .vram_read_att(vram_read_att),
        .isa_op_enable(isa_op_enable), .crtc_addr(crtc_addr),
        .isa_req(isa_req), .isa_we(isa_we), .isa_addr(isa_addr), .isa_din(isa_din),
        .isa_ack(isa_ack), .isa_dout(isa_dout),
        .vram_char(vram_char), .vram_att(vram_att),
        .ram_a(ram_a), .ram_d_in(ram_d_in), .ram_d_out(ram_d_out),
        .ram_we_l(ram_we_l), .ram_oe_l(ram_oe_l), .collision_err(collision_err)
    );

    always #5 clk = ~clk;

    // Sequencer model: 18 states, display fetch in states 2 (char) and 3 (attr).
    int   seq = 0;
    int   cyc = 0;
    logic disp_en = 1'b0;
    logic force_vr = 1'b0;
    always @(posedge clk) begin
        seq <= (seq == 17) ? 0 : seq + 1;
        cyc <= cyc + 1;
    end
    assign vram_read      = (disp_en && (seq == 2 || seq == 3)) || force_vr;
    assign vram_read_a0   = disp_en && (seq == 2);
    assign vram_read_char = disp_en && (seq == 2);
    assign vram_read_att  = disp_en && (seq == 3);
    assign isa_op_enable  = (seq >= 6) && (seq <= 15);

    // SRAM model with a preload port so only one process writes the array.
    logic [7:0]  mem [0:4095];
    logic        pre_we = 1'b0;
    logic [11:0] pre_a = 12'h000;
    logic [7:0]  pre_d = 8'h00;
    assign ram_d_in = !ram_oe_l ? mem[ram_a] : 8'h00;
    always @(posedge clk) begin
        if (pre_we)         mem[pre_a] <= pre_d;
        else if (!ram_we_l) mem[ram_a] <= ram_d_out;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit         chk_data;
        logic [7:0] data;
        int         ack_cyc;
    } exp_t;
    exp_t exp_q[$];

    int          ack_cnt = 0;
    int          we_cnt = 0;
    logic [11:0] we_a = 12'h000;
    logic [7:0]  we_d = 8'h00;
    int          we_seq = -1;

    // Monitor: pops an expectation on every ack and records write strobes.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (isa_ack) begin
                ack_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", int'(isa_ack), 0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.chk_data)     chk("isa_dout", int'(isa_dout), int'(e.data));
                    if (e.ack_cyc >= 0) chk("ack_cycle", cyc, e.ack_cyc);
                end
            end
            if (!ram_we_l) begin
                we_cnt++;
                we_a   = ram_a;
                we_d   = ram_d_out;
                we_seq = seq;
            end
        end
    end

    int ack_base = 0;

    task automatic step();
        @(posedge clk);
        #1;
        if (isa_req && ack_cnt != ack_base) isa_req = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_seq(input int n);
        int k = 0;
        while (seq != n && k < 40) begin
            step();
            k++;
        end
    endtask

    task automatic issue(input bit we, input logic [11:0] a, input logic [7:0] d,
                         input bit push, input bit chk_data, input logic [7:0] exp_d,
                         input int lat);
        exp_t e;
        ack_base = ack_cnt;
        isa_we   = we;
        isa_addr = a;
        isa_din  = d;
        isa_req  = 1'b1;
        if (push) begin
            e.chk_data = chk_data;
            e.data     = exp_d;
            e.ack_cyc  = (lat >= 0) ? cyc + lat : -1;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_ack(input int limit);
        int n = 0;
        while (isa_req && n < limit) begin
            step();
            n++;
        end
        if (isa_req) begin
            chk("ack_timeout", int'(isa_req), 0);
            isa_req = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_ack"},      int'(isa_ack), 0);
        chk({tag, "_dout"},     int'(isa_dout), 0);
        chk({tag, "_char"},     int'(vram_char), 0);
        chk({tag, "_att"},      int'(vram_att), 0);
        chk({tag, "_we_l"},     int'(ram_we_l), 1);
        chk({tag, "_oe_l"},     int'(ram_oe_l), 1);
        chk({tag, "_ram_a"},    int'(ram_a), 0);
        chk({tag, "_d_out"},    int'(ram_d_out), 0);
        chk({tag, "_coll"},     int'(collision_err), 0);
    endtask

    initial begin
        int wb, ab;
        reset = 1'b1;
        isa_req = 1'b0; isa_we = 1'b0; isa_addr = 12'h000; isa_din = 8'h00;
        crtc_addr = 11'h000;

        @(posedge clk); #1;
        pre_we = 1'b1; pre_a = 12'h123; pre_d = 8'h5A;
        @(posedge clk); #1;
        pre_a = 12'hFFF; pre_d = 8'h41;
        @(posedge clk); #1;
        pre_a = 12'hFFE; pre_d = 8'h07;
        @(posedge clk); #1;
        pre_we = 1'b0;
        steps(2);
        reset = 1'b0;
        check_reset_outputs("rst");

        // Read with the window open: ack four cycles after acceptance.
        wait_seq(7);
        wb = we_cnt;
        issue(1'b0, 12'h123, 8'h00, 1'b1, 1'b1, 8'h5A, 4);
        wait_ack(40);
        steps(20);
        chk("rd_no_we", we_cnt - wb, 0);
        chk("rd_one_ack", ack_cnt - ack_base, 1);

        // Write accepted with the window closed; strobe lands inside the next window.
        wait_seq(16);
        wb = we_cnt;
        issue(1'b1, 12'h010, 8'hA5, 1'b1, 1'b0, 8'h00, POSTED ? 1 : -1);
        wait_ack(40);
        steps(30);
        chk("wr_we_count", we_cnt - wb, 1);
        chk("wr_we_addr", int'(we_a), 12'h010);
        chk("wr_we_data", int'(we_d), 8'hA5);
        chk("wr_window", int'(we_seq >= 6 && we_seq <= 17), 1);
        chk("wr_mem", int'(mem[12'h010]), 8'hA5);

        // Display fetch of the last character cell.
        wait_seq(0);
        crtc_addr = 11'h7FF;
        disp_en   = 1'b1;
        wait_seq(3);
        @(negedge clk);
        chk("disp_char", int'(vram_char), 8'h41);
        wait_seq(4);
        @(negedge clk);
        chk("disp_att", int'(vram_att), 8'h07);

        // Display forced into the write strobe cycle: suppressed, then retried.
        wait_seq(7);
        wb = we_cnt;
        issue(1'b1, 12'h030, 8'h77, 1'b1, 1'b0, 8'h00, POSTED ? 1 : -1);
        ab = ack_base;
        steps(3);
        force_vr = 1'b1;
        @(negedge clk);
        chk("coll_we_l", int'(ram_we_l), 1);
        chk("coll_ram_a", int'(ram_a), 12'hFFE);
        step();
        force_vr = 1'b0;
        @(negedge clk);
        chk("coll_err", int'(collision_err), 1);
        wait_ack(40);
        steps(30);
        chk("coll_we_count", we_cnt - wb, 1);
        chk("coll_mem", int'(mem[12'h030]), 8'h77);
        chk("coll_one_ack", ack_cnt - ab, 1);

        // Reset during the strobe of a read: op abandoned, no ack.
        disp_en = 1'b0;
        wait_seq(7);
        issue(1'b0, 12'h123, 8'h00, 1'b0, 1'b0, 8'h00, -1);
        ab = ack_cnt;
        steps(3);
        reset = 1'b1;
        step();
        reset   = 1'b0;
        isa_req = 1'b0;
        check_reset_outputs("midrst");
        steps(20);
        chk("midrst_no_ack", ack_cnt - ab, 0);

`ifdef MDA_POSTED_WRITE_EN
        // Posted write: early ack, memory updated in the window, no second ack.
        wait_seq(7);
        issue(1'b1, 12'h020, 8'h3C, 1'b1, 1'b0, 8'h00, 1);
        ab = ack_base;
        wait_ack(10);
        steps(30);
        chk("post_mem", int'(mem[12'h020]), 8'h3C);
        chk("post_one_ack", ack_cnt - ab, 1);
`endif

        chk("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
